cscore_counter: RTL and testbench

//   Streaming pattern counter for the DUT cscore: one 8-bit ASCII character is

---
 rtl/cscore_counter.sv | 89 ++++++++
 tb/tb_cscore_counter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cscore_counter.sv
// Streaming counter of "cscore" occurrences in a byte stream, one char per clock.
// Optional build macro: CSCORE_CASE_INSENSITIVE_EN folds A-Z to lowercase before matching.
module cscore_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  output logic [CNT_W-1:0] out
);

  // No handshake: every rising edge of clk consumes exactly one char, and out
  // is a plain registered value with no valid qualifier.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C     = 3'd1,
    CS    = 3'd2,
    CSC   = 3'd3,
    CSCO  = 3'd4,
    CSCOR = 3'd5
  } state_t;

  localparam logic [7:0] CH_C = 8'h63;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_O = 8'h6F;
  localparam logic [7:0] CH_R = 8'h72;
  localparam logic [7:0] CH_E = 8'h65;

  state_t     state;
  state_t     state_next;
  logic       hit;
  logic [7:0] ch;

  always_comb begin
    ch = char;
`ifdef CSCORE_CASE_INSENSITIVE_EN
    if (char >= 8'h41 && char <= 8'h5A) ch = char + 8'h20;
`endif
  end

  // Next state is the longest prefix of "cscore" that is a suffix of the input seen so far.
  always_comb begin
    state_next = IDLE;
    hit        = 1'b0;
    unique case (state)
      IDLE: begin
        if (ch == CH_C) state_next = C;
      end
      C: begin
        if (ch == CH_S)      state_next = CS;
        else if (ch == CH_C) state_next = C;
      end
      CS: begin
        if (ch == CH_C) state_next = CSC;
      end
      CSC: begin
        if (ch == CH_O)      state_next = CSCO;
        else if (ch == CH_S) state_next = CS;
        else if (ch == CH_C) state_next = C;
      end
      CSCO: begin
        if (ch == CH_R)      state_next = CSCOR;
        else if (ch == CH_C) state_next = C;
      end
      CSCOR: begin
        if (ch == CH_E) begin
          state_next = IDLE;
          hit        = 1'b1;
        end else if (ch == CH_C) begin
          state_next = C;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Saturating count: once all ones, further matches are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   out <= '0;
    else if (hit && (out != '1)) out <= out + 1'b1;
  end

endmodule

// File: tb/tb_cscore_counter.sv
// Self-checking bench for cscore_counter: randomized and directed char streams
// scored against a sliding-window occurrence model.
module tb_cscore_counter;

  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [7:0]       char;
  logic [CNT_W-1:0] out;

  int checks   = 0;
  int failures = 0;

  logic [CNT_W-1:0] exp_q[$];

  // Reference model: last six (folded) chars, counted whenever they spell "cscore".
  logic [7:0] hist[$];
  int         model_cnt = 0;

  cscore_counter #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .char (char),
    .out  (out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef CSCORE_CASE_INSENSITIVE_EN
    if (c >= "A" && c <= "Z") return c + 8'd32;
`endif
    return c;
  endfunction

  task automatic model_step(input logic [7:0] c);
    string pat;
    bit    match;
    pat = "cscore";
    hist.push_back(fold(c));
    if (hist.size() > 6) void'(hist.pop_front());
    match = (hist.size() == 6);
    for (int i = 0; i < 6; i++)
      if (match && hist[i] != 8'(pat[i])) match = 1'b0;
    if (match && model_cnt < SAT) model_cnt++;
  endtask

  task automatic model_reset();
    hist.delete();
    model_cnt = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: out=%0d expected=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every clock presents a new out; pop the expectation for that edge.
  initial begin
    logic [CNT_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
          failures++;
          $display("FAIL stream: out=%0d expected=%0d at t=%0t", out, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Each driver task consumes exactly one falling edge, so the DUT sees
  // exactly the chars the model sees.
  task automatic drive(input logic [7:0] c);
    @(negedge clk);
    char = c;
    model_step(c);
    exp_q.push_back(CNT_W'(model_cnt));
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) drive(s[i]);
  endtask

  task automatic reset_midcycle();
    @(negedge clk);
    char = 8'h00;
    exp_q.push_back('0);
    #2 reset = 1'b1;
    #1 check("async_reset", int'(out), 0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic send_random(input int n);
    string     alpha;
    logic [7:0] c;
    alpha = "cscoreCSOE";
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        send("cscore");
      end else begin
        if ($urandom_range(0, 9) < 8) c = alpha[$urandom_range(0, alpha.len() - 1)];
        else                          c = 8'($urandom_range(0, 255));
        drive(c);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    char  = 8'h00;
    repeat (3) @(posedge clk);
    #2 check("reset_state", int'(out), 0);
    #1 reset = 1'b0;

    send("score");
    send("cscore");
    send("cscore");
    send("sc");
    send("cscore");

    reset_midcycle();
    send("cscscore");
    reset_midcycle();
    send("cscoccscore");

    reset_midcycle();
    send("cscoe");
    send("csore");
    send("ccsore");
    send("ccscore");

    reset_midcycle();
    send("CSCORE");
    send("CScOrE");

    // Partial match cut short by reset must not complete afterwards.
    reset_midcycle();
    send("csc");
    reset_midcycle();
    send("ore");

    reset_midcycle();
    send_random(1500);

    for (int i = 0; i < 300; i++) send("cscore");
    @(posedge clk);
    #2 check("saturate", int'(out), SAT);
    send_random(400);
    for (int i = 0; i < 5; i++) send("cscore");
    @(posedge clk);
    #2 check("sat_hold", int'(out), SAT);

    reset_midcycle();
    send_random(800);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2 check("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
